inst_fetch: RTL

//  Instruction fetch stage: owns the fetch PC, issues in-order word reads to instruction memory, and

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/inst_fetch_if.sv | 25 ++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/inst_fetch.sv | 122 ++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end.
//   word_t            32-bit machine word / byte address
//   RESET_PC_DEFAULT  default fetch PC after reset
//   INST_NOP          encoding presented when no instruction is available
//   fetch_state_e     fetch stage FSM states
//   fetch_entry_t     one instruction buffer entry {pc, inst}
package cpu_pkg;

    typedef logic [31:0] word_t;

    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
    localparam word_t INST_NOP         = 32'h0000_0000;

    // FLUSH: stale responses from before a redirect are still in flight.
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    typedef struct packed {
        word_t pc;
        word_t inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory bus between the fetch stage (master) and memory (slave).
//   req_valid   master->slave  fetch request
//   req_ready   slave->master  same-cycle grant
//   req_addr    master->slave  word-aligned byte address
//   resp_valid  slave->master  response strobe, in request order, no backpressure
//   resp_data   slave->master  instruction word
interface inst_fetch_if;
    import cpu_pkg::*;

    logic  req_valid;
    logic  req_ready;
    word_t req_addr;
    logic  resp_valid;
    word_t resp_data;

    modport master (
        output req_valid, req_addr,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer holding {pc, inst} entries.
//   clk, rst_n  clock, asynchronous active-low reset
//   push_i      write wdata_i (accepted when not full, or when full and popping)
//   pop_i       drop the head entry (ignored when empty)
//   flush_i     discard all entries; overrides push and pop
//   wdata_i     entry to write
//   head_o      oldest entry, all zeros while empty
//   count_o     number of valid entries
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  fetch_entry_t               wdata_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               empty;
    logic               full;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: the storage array has no reset; entries are only observable
    // through count_q, which is reset, so stale contents are never exposed.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word reads,
// buffers returned words and presents {inst, pc, pc+4} to the decoder.
//   clk, rst_n       clock, asynchronous active-low reset
//   imem             instruction memory bus (master side)
//   redirect_valid   one-cycle control-flow redirect from branch/jump unit
//   redirect_pc      redirect target (low two bits ignored)
//   inst_valid       instruction available to decoder
//   inst_ready       decoder accepts
//   inst, inst_pc    instruction word and its PC (zero while buffer empty)
//   inst_npc         inst_pc + 4 (zero while buffer empty)
module inst_fetch
    import cpu_pkg::*;
#(
    parameter word_t RESET_PC   = RESET_PC_DEFAULT,
    parameter int    FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    inst_fetch_if.master       imem,
    input  logic               redirect_valid,
    input  word_t              redirect_pc,
    output logic               inst_valid,
    input  logic               inst_ready,
    output word_t              inst,
    output word_t              inst_pc,
    output word_t              inst_npc
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(FIFO_DEPTH);

    fetch_state_e       state_q, state_d;
    word_t              fetch_pc_q, fetch_pc_d;
    word_t              resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic               active_q;

    logic [CNT_W-1:0]   fifo_cnt;
    fetch_entry_t       head;
    logic               grant;
    logic               credit_ok;
    logic               push;
    logic               pop;
    word_t              target_pc;

    assign target_pc = redirect_pc & 32'hFFFF_FFFC;

    // Buffered plus outstanding words may never exceed the buffer size, so a
    // response always has room even though memory cannot be back-pressured.
    // Stale in-flight words still count until they come back.
    assign credit_ok      = ({1'b0, fifo_cnt} + {1'b0, inflight_q}) < DEPTH_S;
    // active_q keeps the bus quiet in the cycle reset is released, so every
    // output is zero while rst_n is low without using rst_n as data.
    assign imem.req_valid = active_q && credit_ok && !redirect_valid;
    assign imem.req_addr  = active_q ? fetch_pc_q : '0;
    assign grant          = imem.req_valid && imem.req_ready;

    assign push = imem.resp_valid && !redirect_valid && (drop_q == '0);
    assign pop  = inst_valid && inst_ready && !redirect_valid;

    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned, which would infer a latch.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_d     = drop_q;
        inflight_d = inflight_q + CNT_W'(grant) - CNT_W'(imem.resp_valid);

        if (redirect_valid) begin
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
            drop_d     = inflight_q - CNT_W'(imem.resp_valid);
            state_d    = (drop_d != '0) ? FLUSH : RUN;
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
            if (imem.resp_valid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CNT_W'(1);
                    if (state_q == FLUSH && drop_q == CNT_W'(1)) state_d = RUN;
                end else begin
                    resp_pc_d = resp_pc_q + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            active_q   <= 1'b1;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i ('{pc: resp_pc_q, inst: imem.resp_data}),
        .head_o  (head),
        .count_o (fifo_cnt)
    );

    assign inst_valid = (fifo_cnt != '0);
    assign inst       = inst_valid ? head.inst : INST_NOP;
    assign inst_pc    = head.pc;
    assign inst_npc   = inst_valid ? head.pc + 32'd4 : '0;
endmodule
